cpu_out_uart_tx: RTL

Downstream consumer of the core's memory-mapped output port at 0x7FFFFFFC. Each store to that address produces a one-cycle write strobe plus the 32-bit store data. The block queues each word in a small FIFO and serialises it as four 8N1 UART bytes on a single TxD line. The core never stalls: words that arrive while the FIFO is full are dropped and flagged.

---
 rtl/cpu_out_uart_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cpu_out_uart_tx.sv
// Output-port sink: queues 32-bit store words in a FIFO and sends each as four UART bytes,
// LSB byte first. Define CPU_OUT_TX_PARITY_EN for 8E1 framing instead of 8N1.
module cpu_out_uart_tx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        WrStb,
  input  logic [31:0] WrData,
  output logic        Full,
  output logic        Busy,
  output logic        Overflow,
  output logic        TxD
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
  localparam logic [PtrW:0]    CntFull  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
`ifdef CPU_OUT_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             overflow_q;
  logic             push, pop;

  state_e           state_q;
  logic [31:0]      shreg_q;
  logic [7:0]       cur_byte;
  logic [1:0]       byte_idx_q;
  logic [2:0]       bit_idx_q;
  logic [BaudW-1:0] baud_q;
  logic             baud_end;
  logic             txd_q;

  // Full comes from the registered count, so a same-cycle pop never admits a push.
  assign Full     = (count_q == CntFull);
  assign push     = WrStb & ~Full;
  assign pop      = (state_q == StLoad);
  assign cur_byte = shreg_q[7:0];
  assign baud_end = (baud_q == BaudLast);

  assign Busy     = (state_q != StIdle) | (count_q != '0);
  assign Overflow = overflow_q;
  assign TxD      = txd_q;

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= WrData;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
      if (WrStb && Full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (count_q != '0) state_q <= StLoad;
        end
        StLoad: begin
          shreg_q    <= mem_q[rd_ptr_q];
          byte_idx_q <= '0;
          baud_q     <= '0;
          txd_q      <= 1'b0;
          state_q    <= StStart;
        end
        StStart: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= cur_byte[0];
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef CPU_OUT_TX_PARITY_EN
              txd_q   <= ^cur_byte;
              state_q <= StParity;
`else
              txd_q   <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef CPU_OUT_TX_PARITY_EN
        StParity: begin
          if (baud_end) begin
            baud_q  <= '0;
            txd_q   <= 1'b1;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_idx_q != 2'd3) begin
              // Next byte of the same word follows with no idle gap.
              byte_idx_q <= byte_idx_q + 2'd1;
              shreg_q    <= {8'h00, shreg_q[31:8]};
              txd_q      <= 1'b0;
              state_q    <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
